usb_tx_arbiter: RTL and testbench

USB_TX_ARBITER -- requirements
Module: usb_tx_arbiter

---
 rtl/usb_tx_arbiter_pkg.sv | 14 +
 rtl/usb_tx_arbiter_rr_pick.sv | 26 ++
 rtl/usb_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_usb_tx_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_arbiter_pkg.sv
// Shared types and constants for the USB byte-transmit arbiter.
// Holds the lock-FSM state encoding and the stall-timeout default.
package usb_tx_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 4096;
    localparam int unsigned GRANT_W         = 3;
    localparam int unsigned IDLE_CNT_W      = 16;

endpackage

// File: rtl/usb_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning
// upward from (last+1) mod N, wrapping around.
module rr_pick
    import usb_tx_arbiter_pkg::*;
#(
    parameter int unsigned N = 4
)(
    input  logic [N-1:0]       req,
    input  logic [GRANT_W-1:0] last,
    output logic               found,
    output logic [GRANT_W-1:0] index
);

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (req[(32'(last) + N - k) % N]) begin
                found = 1'b1;
                index = GRANT_W'((32'(last) + N - k) % N);
            end
        end
    end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Packet-locking round-robin arbiter feeding single bytes to the usb_serial
// transmitter; every output comes straight from a flop.
module usb_tx_arbiter
    import usb_tx_arbiter_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
)(
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ack,
    input  logic           tx_ready,
    output logic           tx_strobe,
    output logic [7:0]     tx_data,
    output logic [2:0]     grant_id,
    output logic           busy
);

    localparam logic [IDLE_CNT_W-1:0] IDLE_LIMIT = IDLE_CNT_W'(TIMEOUT - 1);
    localparam logic [GRANT_W-1:0]    LAST_INIT  = GRANT_W'(N - 1);

    arb_state_e            state_q, state_d;
    logic [GRANT_W-1:0]    last_grant_q, last_grant_d;
    logic [GRANT_W-1:0]    grant_q, grant_d;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic                  tx_strobe_q, tx_strobe_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic [N-1:0]          req_ack_q, req_ack_d;

    logic                  pick_found;
    logic [GRANT_W-1:0]    pick_index;
    logic                  sel_valid;
    logic                  sel_last;
    logic [7:0]            sel_data;
    logic [N-1:0]          grant_onehot;

    rr_pick #(.N(N)) u_rr_pick (
        .req   (req_valid),
        .last  (last_grant_q),
        .found (pick_found),
        .index (pick_index)
    );

    always_comb begin : grant_mux
        sel_valid    = 1'b0;
        sel_last     = 1'b0;
        sel_data     = '0;
        grant_onehot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_q == GRANT_W'(i)) begin
                sel_valid       = req_valid[i];
                sel_last        = req_last[i];
                sel_data        = req_data[8*i +: 8];
                grant_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin : next_state
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        idle_cnt_d   = idle_cnt_q;
        tx_strobe_d  = 1'b0;
        tx_data_d    = tx_data_q;
        req_ack_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d    = ST_LOCKED;
                    grant_d    = pick_index;
                    idle_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                // The strobe flop doubles as the issue gate: sink ready lags by one cycle.
                if (sel_valid && tx_ready && !tx_strobe_q) begin
                    tx_strobe_d = 1'b1;
                    tx_data_d   = sel_data;
                    req_ack_d   = grant_onehot;
                    idle_cnt_d  = '0;
                    if (sel_last) begin
                        state_d      = ST_IDLE;
                        last_grant_d = grant_q;
                        grant_d      = '0;
                    end
                end else if (!sel_valid) begin
                    if (idle_cnt_q == IDLE_LIMIT) begin
                        state_d      = ST_IDLE;
                        last_grant_d = grant_q;
                        grant_d      = '0;
                        idle_cnt_d   = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LAST_INIT;
            grant_q      <= '0;
            idle_cnt_q   <= '0;
            tx_strobe_q  <= 1'b0;
            tx_data_q    <= '0;
            req_ack_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            idle_cnt_q   <= idle_cnt_d;
            tx_strobe_q  <= tx_strobe_d;
            tx_data_q    <= tx_data_d;
            req_ack_q    <= req_ack_d;
        end
    end

    assign req_ack   = req_ack_q;
    assign tx_strobe = tx_strobe_q;
    assign tx_data   = tx_data_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Bench for usb_tx_arbiter: a directed vector table, hand sequences for the
// multi-cycle corners, and random packet traffic against a queue-based model.
module tb_usb_tx_arbiter;

    localparam int N   = 4;
    localparam int TMO = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ack;
    logic           tx_ready;
    logic           tx_strobe;
    logic [7:0]     tx_data;
    logic [2:0]     grant_id;
    logic           busy;

    usb_tx_arbiter #(.N(N), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ack   (req_ack),
        .tx_ready  (tx_ready),
        .tx_strobe (tx_strobe),
        .tx_data   (tx_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic           rst;
        logic [N-1:0]   v;
        logic [8*N-1:0] d;
        logic [N-1:0]   l;
        logic           rdy;
        logic           s;
        logic [7:0]     td;
        logic [N-1:0]   ack;
        logic           bsy;
        logic [2:0]     gid;
    } vec_t;

    vec_t vt[15];

    // Reference model state: per-requester byte queues plus packet ownership.
    logic [7:0] q_data[N][$];
    bit         q_last[N][$];
    bit         hold_off[N];
    int         ready_mode;
    int         owner;
    int         last_g;
    int         idle;
    logic [7:0] hold_data;
    bit         prev_strobe;
    int         ack_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_expect();
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last_g + k) % N;
            if (q_data[i].size() > 0 && !hold_off[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++)
            if (q_data[i].size() > 0 && !hold_off[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (q_data[i].size() > 0 && !hold_off[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = q_data[i][0];
                req_last[i]        = q_last[i][0];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'b0;
            default: tx_ready = ($urandom_range(3) != 0);
        endcase
    endtask

    task automatic push_packet(input int r, input int len, input logic [7:0] base);
        for (int k = 0; k < len; k++) begin
            q_data[r].push_back(base + 8'(k));
            q_last[r].push_back(k == len - 1);
        end
    endtask

    task automatic step();
        logic [N-1:0] v_edge;
        logic         r_edge;
        int           id;
        bit           lst;
        v_edge = req_valid;
        r_edge = tx_ready;
        @(posedge clk);
        #1;
        chk("no_back_to_back", 32'(tx_strobe & prev_strobe), 32'd0);
        chk("ack_with_strobe", 32'(req_ack != '0), 32'(tx_strobe));
        chk("ack_onehot", 32'($onehot0(req_ack)), 32'd1);
        if (!busy) chk("grant_id_idle", 32'(grant_id), 32'd0);
        if (tx_strobe && req_ack != '0) begin
            id = 0;
            for (int i = 0; i < N; i++) if (req_ack[i]) id = i;
            ack_log.push_back(id);
            chk("strobe_after_ready", 32'(r_edge), 32'd1);
            chk("acked_was_valid", 32'(v_edge[id]), 32'd1);
            if (owner < 0) begin
                chk("grant_order", 32'(id), 32'(rr_expect()));
                owner = id;
            end else begin
                chk("packet_owner", 32'(id), 32'(owner));
            end
            if (q_data[id].size() > 0) begin
                chk("tx_data", 32'(tx_data), 32'(q_data[id][0]));
                hold_data = q_data[id][0];
                lst = q_last[id][0];
                void'(q_data[id].pop_front());
                void'(q_last[id].pop_front());
                idle = 0;
                if (lst) begin
                    last_g = id;
                    owner  = -1;
                    chk("busy_after_last", 32'(busy), 32'd0);
                end else begin
                    chk("busy_mid_packet", 32'(busy), 32'd1);
                end
            end
        end else begin
            chk("tx_data_hold", 32'(tx_data), 32'(hold_data));
            if (owner >= 0) begin
                if (!v_edge[owner]) idle++;
                if (idle >= TMO) begin
                    chk("timeout_release", 32'(busy), 32'd0);
                    last_g = owner;
                    owner  = -1;
                    idle   = 0;
                end else begin
                    chk("busy_locked", 32'(busy), 32'd1);
                end
            end
        end
        prev_strobe = tx_strobe;
        drive();
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b1;
        for (int i = 0; i < N; i++) begin
            q_data[i].delete();
            q_last[i].delete();
            hold_off[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("rst_strobe", 32'(tx_strobe), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        reset       = 1'b0;
        owner       = -1;
        last_g      = N - 1;
        idle        = 0;
        hold_data   = 8'h00;
        prev_strobe = 1'b0;
        ready_mode  = 0;
        ack_log.delete();
        drive();
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((pending() || busy) && n < limit) begin
            step();
            n++;
        end
        chk("drain_in_time", 32'(n < limit), 32'd1);
        repeat (3) step();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int exp_order[12];

        // rst, valid, data, last, ready | strobe, tx_data, ack, busy, grant_id
        vt[0]  = '{1'b1, 4'h0, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0};
        vt[1]  = '{1'b0, 4'h1, 32'h0000_0041, 4'h1, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 3'd0};
        vt[2]  = '{1'b0, 4'h1, 32'h0000_0041, 4'h1, 1'b1, 1'b1, 8'h41, 4'h1, 1'b0, 3'd0};
        vt[3]  = '{1'b0, 4'h0, 32'h0000_0041, 4'h0, 1'b1, 1'b0, 8'h41, 4'h0, 1'b0, 3'd0};
        vt[4]  = '{1'b0, 4'h3, 32'h0000_5210, 4'h0, 1'b1, 1'b0, 8'h41, 4'h0, 1'b1, 3'd1};
        vt[5]  = '{1'b0, 4'h3, 32'h0000_5210, 4'h0, 1'b1, 1'b1, 8'h52, 4'h2, 1'b1, 3'd1};
        vt[6]  = '{1'b0, 4'h3, 32'h0000_5310, 4'h0, 1'b1, 1'b0, 8'h52, 4'h0, 1'b1, 3'd1};
        vt[7]  = '{1'b0, 4'h3, 32'h0000_5310, 4'h0, 1'b1, 1'b1, 8'h53, 4'h2, 1'b1, 3'd1};
        vt[8]  = '{1'b1, 4'h3, 32'h0000_5310, 4'h0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0};
        vt[9]  = '{1'b0, 4'h3, 32'h0000_5410, 4'h1, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 3'd0};
        vt[10] = '{1'b0, 4'h3, 32'h0000_5410, 4'h1, 1'b1, 1'b1, 8'h10, 4'h1, 1'b0, 3'd0};
        vt[11] = '{1'b0, 4'h2, 32'h0000_5400, 4'h2, 1'b1, 1'b0, 8'h10, 4'h0, 1'b1, 3'd1};
        vt[12] = '{1'b0, 4'h2, 32'h0000_5400, 4'h2, 1'b0, 1'b0, 8'h10, 4'h0, 1'b1, 3'd1};
        vt[13] = '{1'b0, 4'h2, 32'h0000_5400, 4'h2, 1'b1, 1'b1, 8'h54, 4'h2, 1'b0, 3'd0};
        vt[14] = '{1'b0, 4'h0, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 8'h54, 4'h0, 1'b0, 3'd0};

        for (int k = 0; k < 15; k++) begin
            reset     = vt[k].rst;
            req_valid = vt[k].v;
            req_data  = vt[k].d;
            req_last  = vt[k].l;
            tx_ready  = vt[k].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_strobe", k), 32'(tx_strobe), 32'(vt[k].s));
            chk($sformatf("vec%0d_data", k), 32'(tx_data), 32'(vt[k].td));
            chk($sformatf("vec%0d_ack", k), 32'(req_ack), 32'(vt[k].ack));
            chk($sformatf("vec%0d_busy", k), 32'(busy), 32'(vt[k].bsy));
            chk($sformatf("vec%0d_grant", k), 32'(grant_id), 32'(vt[k].gid));
        end

        // Two continuously-valid requesters alternate whole packets.
        reset_dut();
        for (int p = 0; p < 2; p++) begin
            push_packet(0, 3, 8'h00 + 8'(p * 16));
            push_packet(2, 3, 8'h80 + 8'(p * 16));
        end
        drive();
        drain(200);
        exp_order = '{0, 0, 0, 2, 2, 2, 0, 0, 0, 2, 2, 2};
        chk("interleave_count", 32'(ack_log.size()), 32'd12);
        for (int k = 0; k < 12 && k < ack_log.size(); k++)
            chk($sformatf("interleave_order%0d", k), 32'(ack_log[k]), 32'(exp_order[k]));

        // Streaming requester with the sink always ready: strobe every second cycle.
        reset_dut();
        push_packet(3, 30, 8'h40);
        drive();
        n = 0;
        while (!tx_strobe && n < 10) begin
            step();
            n++;
        end
        chk("stream_first_strobe", 32'(tx_strobe), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("stream_period", 32'(tx_strobe), 32'(k % 2 == 0));
        end
        drain(200);

        // Requester 1 stalls mid-packet; lock released after TMO idle cycles.
        reset_dut();
        push_packet(1, 3, 8'h10);
        push_packet(2, 1, 8'hC2);
        drive();
        n = 0;
        while (ack_log.size() == 0 && n < 10) begin
            step();
            n++;
        end
        chk("stall_first_ack", 32'(ack_log.size()), 32'd1);
        hold_off[1] = 1'b1;
        drive();
        n = 0;
        while (owner >= 0 && n < 30) begin
            step();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'(TMO));
        q_data[1].delete();
        q_last[1].delete();
        hold_off[1] = 1'b0;
        drive();
        drain(50);
        chk("after_timeout_count", 32'(ack_log.size()), 32'd2);
        if (ack_log.size() >= 2) chk("after_timeout_grant", 32'(ack_log[1]), 32'd2);

        // Sink not ready for 50 cycles while locked with valid data.
        reset_dut();
        push_packet(0, 3, 8'h60);
        drive();
        n = 0;
        while (ack_log.size() == 0 && n < 10) begin
            step();
            n++;
        end
        ready_mode = 1;
        drive();
        repeat (50) step();
        chk("stall_no_ack", 32'(ack_log.size()), 32'd1);
        chk("stall_still_busy", 32'(busy), 32'd1);
        ready_mode = 0;
        drive();
        drain(50);
        chk("stall_total_bytes", 32'(ack_log.size()), 32'd3);

        // Random packet traffic with a random sink.
        for (int it = 0; it < 8; it++) begin
            reset_dut();
            for (int r = 0; r < N; r++) begin
                int np;
                np = $urandom_range(3);
                for (int p = 0; p < np; p++)
                    push_packet(r, $urandom_range(4, 1), 8'($urandom));
            end
            ready_mode = 2;
            drive();
            drain(800);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
